// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs,
// blank pattern and all-anodes-off value.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-glyph decoder; segments are active-low,
// glyph[0]=a .. glyph[6]=g.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment scanner with per-frame input capture
// and inter-digit blanking. Define SEG7_LZ_SUPPRESS_EN for leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 100000,
    parameter int BLANK  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int              CNT_W     = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [31:0]      value_sh_reg;
    logic [7:0]       dp_sh_reg, en_sh_reg;
    logic [7:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_n_reg, dp_n_next;
    logic             tick_reg;

    logic             frame_start;
    logic [31:0]      value_cur;
    logic [7:0]       dp_cur, en_cur;
    logic [3:0]       nib [8];
    logic [7:0]       show_mask;
    logic [6:0]       glyph;
    logic             an_on;

    assign frame_start = (cnt_reg == '0) && (idx_reg == 3'd0);

    // The frame-start cycle already drives slot 0 from the freshly captured
    // inputs, so the first output of each frame belongs to the new frame.
    assign value_cur = frame_start ? value    : value_sh_reg;
    assign dp_cur    = frame_start ? dp       : dp_sh_reg;
    assign en_cur    = frame_start ? digit_en : en_sh_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign nib[gi] = value_cur[4*gi +: 4];
        end
    endgenerate

`ifdef SEG7_LZ_SUPPRESS_EN
    // Scan from the top digit down; a digit is shown once any nonzero nibble
    // or decimal point has been seen at or above it. Digit 0 always shows.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        show_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (nib[i] != 4'h0) | dp_cur[i] | (i == 0);
            show_mask[i] = seen;
        end
    end
`else
    assign show_mask = 8'hFF;
`endif

    hex7seg u_hex7seg (
        .nibble (nib[idx_reg]),
        .glyph  (glyph)
    );

    always_comb begin
        cnt_next  = cnt_reg + 1'b1;
        idx_next  = idx_reg;
        an_next   = AN_OFF;
        an_on     = (cnt_reg >= CNT_BLANK) && en_cur[idx_reg];
        seg_next  = show_mask[idx_reg] ? glyph : SEG_BLANK;
        dp_n_next = ~(an_on & dp_cur[idx_reg]);
        if (an_on) begin
            an_next[idx_reg] = 1'b0;
        end
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            idx_reg      <= 3'd0;
            value_sh_reg <= '0;
            dp_sh_reg    <= '0;
            en_sh_reg    <= '0;
            an_reg       <= AN_OFF;
            seg_reg      <= SEG_BLANK;
            dp_n_reg     <= 1'b1;
            tick_reg     <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            an_reg   <= an_next;
            seg_reg  <= seg_next;
            dp_n_reg <= dp_n_next;
            tick_reg <= frame_start;
            if (frame_start) begin
                value_sh_reg <= value;
                dp_sh_reg    <= dp;
                en_sh_reg    <= digit_en;
            end
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp_n       = dp_n_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=8, DWELL=8, BLANK=2
// (frame = 64 cycles, anode on for cycles 2..7 of each slot).
module tb_seg7_scan;

`ifdef SEG7_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int k = 0;

    seg7_scan #(.DIGITS(8), .DWELL(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
        int          slot;
        logic [6:0]  seg;
        bit          on;
        bit          dp_lit;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    // After this, the next edge is the frame-start state; its sample is k=0.
    task automatic restart();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        k = -1;
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] exp_an;
        logic [6:0] prev_seg;
        int low_cnt [8];
        int fall_cnt [8];
        int hi_run, min_gap, overlap, seg_glitch, hi_dis, t0, t1, dp_low, dp_bad;

        vecs.push_back('{32'h0123_4567, 8'h00, 8'hFF, 0, 7'h78, 1'b1, 1'b0});
        vecs.push_back('{32'h0123_4567, 8'h00, 8'hFF, 3, 7'h19, 1'b1, 1'b0});
        vecs.push_back('{32'h0123_4567, 8'h00, 8'hFF, 4, 7'h30, 1'b1, 1'b0});
        vecs.push_back('{32'h0123_4567, 8'h00, 8'hFF, 7, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 0, 7'h0E, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 1, 7'h06, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 2, 7'h21, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 3, 7'h46, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 4, 7'h03, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 5, 7'h08, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 6, 7'h10, 1'b1, 1'b0});
        vecs.push_back('{32'h89AB_CDEF, 8'h00, 8'hFF, 7, 7'h00, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 8'h01, 8'hFF, 0, 7'h40, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_0000, 8'h01, 8'hFF, 1, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0050, 8'h00, 8'hFF, 1, 7'h12, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0050, 8'h00, 8'hFF, 2, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0050, 8'h00, 8'hFF, 0, 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 8'h10, 8'hFF, 4, 7'h40, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_0000, 8'h10, 8'hFF, 5, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 8'h10, 8'hFF, 3, 7'h40, 1'b1, 1'b0});
        vecs.push_back('{32'h1111_1111, 8'h00, 8'h0F, 5, 7'h79, 1'b0, 1'b0});
        vecs.push_back('{32'h1111_1111, 8'h00, 8'h0F, 2, 7'h79, 1'b1, 1'b0});
        vecs.push_back('{32'h1111_1111, 8'h20, 8'h0F, 5, 7'h79, 1'b0, 1'b0});

        // Reset state
        step();
        step();
        check("reset_an", an, 8'hFF);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp_n", dp_n, 1'b1);
        check("reset_tick", frame_tick, 1'b0);
        $display("reset: an=%h seg=%h dp_n=%b tick=%b", an, seg, dp_n, frame_tick);

        // Table-driven display vectors
        for (int i = 0; i < vecs.size(); i++) begin
            value    = vecs[i].value;
            dp       = vecs[i].dp;
            digit_en = vecs[i].en;
            restart();
            exp_an = vecs[i].on ? ~(8'h01 << vecs[i].slot) : 8'hFF;
            step_to(vecs[i].slot * 8);
            check($sformatf("v%0d_blank_an", i), an, 8'hFF);
            check($sformatf("v%0d_blank_seg", i), seg, vecs[i].seg);
            step_to(vecs[i].slot * 8 + 4);
            check($sformatf("v%0d_an", i), an, exp_an);
            check($sformatf("v%0d_seg", i), seg, vecs[i].seg);
            check($sformatf("v%0d_dp_n", i), dp_n, !vecs[i].dp_lit);
            $display("vec %0d: value=%h dp=%h en=%h slot=%0d an=%h seg=%h dp_n=%b",
                     i, vecs[i].value, vecs[i].dp, vecs[i].en, vecs[i].slot, an, seg, dp_n);
        end

        // Reset mid-scan at idx 3
        value = 32'h0123_4567; dp = 8'h00; digit_en = 8'hFF;
        restart();
        step_to(27);
        check("midrst_pre_an", an, 8'hF7);
        rst = 1'b1;
        step();
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp_n", dp_n, 1'b1);
        rst = 1'b0;
        k = -1;
        step();
        check("midrst_tick", frame_tick, 1'b1);
        check("midrst_slot0_seg", seg, 7'h78);
        check("midrst_slot0_an", an, 8'hFF);
        step();
        check("midrst_tick_once", frame_tick, 1'b0);
        $display("reset mid-scan: restart seg=%h", seg);

        // Frame capture: change value during slot 4
        value = 32'h1111_1111;
        restart();
        step_to(33);
        value = 32'h2222_2222;
        for (int s = 5; s < 8; s++) begin
            step_to(s * 8 + 4);
            check($sformatf("capture_slot%0d_seg", s), seg, 7'h79);
        end
        step_to(64);
        check("capture_tick64", frame_tick, 1'b1);
        step_to(68);
        check("capture_next_seg", seg, 7'h24);
        $display("frame capture: next frame seg=%h", seg);

        // Disabled digits and frame period
        value = 32'h1234_5678; digit_en = 8'h0F;
        restart();
        hi_dis = 0; t0 = -1; t1 = -1;
        for (int c = 0; c < 130; c++) begin
            step();
            if (an[7:4] != 4'hF) hi_dis++;
            if (frame_tick) begin
                if (t0 < 0) t0 = k;
                else if (t1 < 0) t1 = k;
            end
        end
        check("disabled_an_hi_viol", hi_dis, 0);
        check("disabled_tick_first", t0, 0);
        check("disabled_tick_period", t1 - t0, 64);
        $display("disabled digits: ticks at %0d and %0d", t0, t1);

        // Blanking, exclusivity, seg stability
        value = 32'h89AB_CDEF; digit_en = 8'hFF; dp = 8'h01;
        restart();
        for (int j = 0; j < 8; j++) begin low_cnt[j] = 0; fall_cnt[j] = 0; end
        hi_run = 0; min_gap = 1000; overlap = 0; seg_glitch = 0; dp_low = 0; dp_bad = 0;
        prev_seg = seg;
        for (int c = 0; c < 64; c++) begin
            step();
            if ($countones(~an) > 1) overlap++;
            if (seg !== prev_seg && an !== 8'hFF) seg_glitch++;
            prev_seg = seg;
            if (an == 8'hFF) begin
                hi_run++;
            end else begin
                if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
            end
            for (int j = 0; j < 8; j++) begin
                if (!an[j]) low_cnt[j]++;
                if (!an[j] && (c == 0 || (k % 8) == 2)) fall_cnt[j]++;
            end
            if (!dp_n) begin
                dp_low++;
                if (an[0]) dp_bad++;
            end
        end
        for (int j = 0; j < 8; j++) begin
            check($sformatf("blank_low_cnt%0d", j), low_cnt[j], 6);
            check($sformatf("blank_runs%0d", j), fall_cnt[j], 1);
        end
        check("blank_min_gap_ge2", min_gap >= 2, 1'b1);
        check("blank_overlap", overlap, 0);
        check("seg_change_while_lit", seg_glitch, 0);
        check("dp_low_cycles", dp_low, 6);
        check("dp_outside_an0", dp_bad, 0);
        $display("blanking: min_gap=%0d overlap=%0d dp_low=%0d", min_gap, overlap, dp_low);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
